// File: rtl/hex_entry_input_pkg.sv
// hex_entry_input_pkg: shared FSM encodings, default parameters and sizing helper for the hex entry path
package hex_entry_input_pkg;
    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_OFFER   = 1'b1
    } state_t;
    localparam int DEF_DATA_WIDTH      = 16;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/hex_entry_input_key_debounce.sv
// key_debounce: synchronises one raw pushbutton, debounces it and emits a single-cycle press pulse
//   clk, rst (sync, active-low) | raw: asynchronous button | level: debounced level | press: rising-edge pulse
module key_debounce
    import hex_entry_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    logic          s1, s2, level_q;
    logic [CW-1:0] cnt;
    // the counter only runs while the synchronised input disagrees with the accepted level,
    // so any return to the old level restarts the stability window
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            s1      <= raw;
            s2      <= s1;
            level_q <= level;
            if (s2 == level)
                cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= s2;
                cnt   <= '0;
            end else
                cnt <= cnt + 1'b1;
        end
    end
    assign press = level & ~level_q;
endmodule

// File: rtl/hex_entry_input.sv
// hex_entry_input: assembles a word from switch nibbles entered with ENTER/CLEAR and offers it over valid/ready
//   clk, rst (sync, active-low) | sw, key_enter, key_clear: raw asynchronous inputs
//   out_data/out_valid/out_ready: word handshake | cur_nibble: synchronised switches | nib_count: nibbles entered
module hex_entry_input
    import hex_entry_input_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    sw,
    input  logic                          key_enter,
    input  logic                          key_clear,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [3:0]                    cur_nibble,
    output logic [$clog2(DATA_WIDTH/4):0] nib_count
);
    localparam int NW = DATA_WIDTH / 4;
    localparam int CW = $clog2(NW) + 1;
    logic [3:0]            sw_s1;
    logic                  enter_press, clear_press;
    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] data_n;
    logic [CW-1:0]         cnt_n;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk(clk), .rst(rst), .raw(key_enter), .level(), .press(enter_press)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk(clk), .rst(rst), .raw(key_clear), .level(), .press(clear_press)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            sw_s1      <= '0;
            cur_nibble <= '0;
            state      <= ST_COLLECT;
            out_data   <= '0;
            nib_count  <= '0;
        end else begin
            sw_s1      <= sw;
            cur_nibble <= sw_s1;
            state      <= state_n;
            out_data   <= data_n;
            nib_count  <= cnt_n;
        end
    end

    // key presses are dropped while a word is on offer; clear beats a simultaneous enter
    always_comb begin
        state_n = state;
        data_n  = out_data;
        cnt_n   = nib_count;
        if (state == ST_OFFER) begin
            if (out_ready) begin
                state_n = ST_COLLECT;
                data_n  = '0;
                cnt_n   = '0;
            end
        end else if (clear_press) begin
            data_n = '0;
            cnt_n  = '0;
        end else if (enter_press) begin
            data_n  = {out_data[DATA_WIDTH-5:0], cur_nibble};
            cnt_n   = nib_count + 1'b1;
            state_n = (cnt_n == CW'(NW)) ? ST_OFFER : ST_COLLECT;
        end
    end

    // derived from the registered state only, so out_ready never reaches out_valid combinationally
    assign out_valid = (state == ST_OFFER);
endmodule

// File: tb/tb_hex_entry_input.sv
// tb_hex_entry_input: directed vector bench for hex_entry_input with fast debounce
module tb_hex_entry_input;
    logic        clk, rst, key_enter, key_clear, out_ready, out_valid;
    logic [3:0]  sw, cur_nibble;
    logic [15:0] out_data;
    logic [2:0]  nib_count;
    int          n_chk, n_fail;

    typedef struct {
        logic [3:0]  sw;
        logic [1:0]  op;
        logic [15:0] data;
        logic [2:0]  cnt;
        logic        valid;
    } vec_t;
    vec_t vecs[19];

    hex_entry_input #(.DATA_WIDTH(16), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .sw(sw), .key_enter(key_enter), .key_clear(key_clear),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .cur_nibble(cur_nibble), .nib_count(nib_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // op: 0 enter, 1 clear, 2 enter+clear together, 3 one-cycle out_ready
    task automatic do_op(input logic [3:0] s, input logic [1:0] op);
        sw = s;
        tick(3);
        if (op == 2'd3) begin
            out_ready = 1'b1;
            tick(1);
            out_ready = 1'b0;
        end else begin
            key_enter = (op != 2'd1);
            key_clear = (op != 2'd0);
            tick(8);
            key_enter = 1'b0;
            key_clear = 1'b0;
            tick(8);
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        vecs[0]  = '{4'hA, 2'd0, 16'h000A, 3'd1, 1'b0};
        vecs[1]  = '{4'hB, 2'd0, 16'h00AB, 3'd2, 1'b0};
        vecs[2]  = '{4'hC, 2'd0, 16'h0ABC, 3'd3, 1'b0};
        vecs[3]  = '{4'hD, 2'd0, 16'hABCD, 3'd4, 1'b1};
        vecs[4]  = '{4'h5, 2'd0, 16'hABCD, 3'd4, 1'b1};
        vecs[5]  = '{4'h6, 2'd1, 16'hABCD, 3'd4, 1'b1};
        vecs[6]  = '{4'h7, 2'd2, 16'hABCD, 3'd4, 1'b1};
        vecs[7]  = '{4'h0, 2'd3, 16'h0000, 3'd0, 1'b0};
        vecs[8]  = '{4'h3, 2'd0, 16'h0003, 3'd1, 1'b0};
        vecs[9]  = '{4'h5, 2'd0, 16'h0035, 3'd2, 1'b0};
        vecs[10] = '{4'h5, 2'd3, 16'h0035, 3'd2, 1'b0};
        vecs[11] = '{4'h8, 2'd1, 16'h0000, 3'd0, 1'b0};
        vecs[12] = '{4'h1, 2'd0, 16'h0001, 3'd1, 1'b0};
        vecs[13] = '{4'h2, 2'd0, 16'h0012, 3'd2, 1'b0};
        vecs[14] = '{4'h3, 2'd0, 16'h0123, 3'd3, 1'b0};
        vecs[15] = '{4'h4, 2'd0, 16'h1234, 3'd4, 1'b1};
        vecs[16] = '{4'h0, 2'd3, 16'h0000, 3'd0, 1'b0};
        vecs[17] = '{4'h7, 2'd0, 16'h0007, 3'd1, 1'b0};
        vecs[18] = '{4'hE, 2'd2, 16'h0000, 3'd0, 1'b0};

        rst = 1'b0;
        sw = 4'hF;
        key_enter = 1'b1;
        key_clear = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            key_enter = ~key_enter;
            key_clear = ~key_clear;
        end
        check("rst_data", out_data, 16'h0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_cnt", nib_count, 3'd0);
        check("rst_nibble", cur_nibble, 4'h0);
        key_enter = 1'b0;
        key_clear = 1'b0;
        sw = 4'h0;
        rst = 1'b1;
        tick(12);
        check("rst_release_cnt", nib_count, 3'd0);
        check("rst_release_data", out_data, 16'h0);

        for (int i = 0; i < 19; i++) begin
            do_op(vecs[i].sw, vecs[i].op);
            check($sformatf("vec%0d_data", i), out_data, vecs[i].data);
            check($sformatf("vec%0d_cnt", i), nib_count, vecs[i].cnt);
            check($sformatf("vec%0d_valid", i), out_valid, vecs[i].valid);
        end

        sw = 4'h9;
        tick(3);
        check("sw_sync", cur_nibble, 4'h9);
        key_enter = 1'b1;
        tick(6);
        check("latency_early", nib_count, 3'd0);
        tick(1);
        check("latency_exact", nib_count, 3'd1);
        check("latency_data", out_data, 16'h0009);
        key_enter = 1'b0;
        tick(8);

        sw = 4'h6;
        tick(3);
        for (int i = 0; i < 10; i++) begin
            key_enter = (i % 2 == 0);
            tick(2);
        end
        check("bounce_none", nib_count, 3'd1);
        key_enter = 1'b1;
        tick(10);
        key_enter = 1'b0;
        tick(8);
        check("bounce_one_cnt", nib_count, 3'd2);
        check("bounce_one_data", out_data, 16'h0096);

        rst = 1'b0;
        tick(1);
        check("midrst_cnt", nib_count, 3'd0);
        check("midrst_data", out_data, 16'h0);
        check("midrst_valid", out_valid, 1'b0);
        rst = 1'b1;
        do_op(4'hC, 2'd0);
        check("post_rst_data", out_data, 16'h000C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
